// File: rtl/hilo_pkg.sv
// ============================================================================
// Module      : hilo_pkg
// Description : Shared encodings for the HI/LO sequencer: request opcodes,
//               FSM states and the mult/div core control codes.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package hilo_pkg;

    // Request opcode carried on op_i; unlisted values behave as NOP
    typedef enum logic [2:0] {
        OP_NOP  = 3'd0,
        OP_MULT = 3'd1,
        OP_DIV  = 3'd2,
        OP_MTHI = 3'd3,
        OP_MTLO = 3'd4
    } hilo_op_e;

    // Sequencer FSM states
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CLR  = 2'd1,
        ST_RUN  = 2'd2,
        ST_CAPT = 2'd3
    } hilo_state_e;

    // Control codes driven to the mult/div core
    localparam logic [1:0] CORE_IDLE = 2'b00;
    localparam logic [1:0] CORE_MULT = 2'b01;
    localparam logic [1:0] CORE_DIV  = 2'b10;

endpackage : hilo_pkg

`default_nettype wire

// File: rtl/hilo_regfile.sv
// ============================================================================
// Module      : hilo_regfile
// Description : Architectural HI/LO registers. Captures core results at the
//               end of CAPT, accepts MTHI/MTLO writes, and serves MFHI/MFLO
//               reads. With HILO_FWD_EN defined, reads during CAPT are
//               forwarded straight from the core result buses.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module hilo_regfile #(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              capt_i,
    input  logic              flush_i,
    input  logic              wr_hi_i,
    input  logic              wr_lo_i,
    input  logic [DATA_W-1:0] wr_data_i,
    input  logic [DATA_W-1:0] core_hi_i,
    input  logic [DATA_W-1:0] core_lo_i,
    input  logic              rd_sel_i,
    output logic [DATA_W-1:0] rd_data_o
);

    logic [DATA_W-1:0] hi_q;
    logic [DATA_W-1:0] lo_q;
    logic              w_cap_en;

    // A flush in CAPT cancels the capture
    assign w_cap_en = capt_i & ~flush_i;

    // HI/LO update: core capture or MT* write (never in the same cycle)
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            hi_q <= '0;
            lo_q <= '0;
        end else if (w_cap_en) begin
            hi_q <= core_hi_i;
            lo_q <= core_lo_i;
        end else begin
            if (wr_hi_i) hi_q <= wr_data_i;
            if (wr_lo_i) lo_q <= wr_data_i;
        end
    end

`ifdef HILO_FWD_EN
    // Read mux, bypassing to the core result while it is being captured
    always_comb begin
        if (capt_i) rd_data_o = rd_sel_i ? core_lo_i : core_hi_i;
        else        rd_data_o = rd_sel_i ? lo_q : hi_q;
    end
`else
    // Read mux straight from the architectural registers
    always_comb begin
        rd_data_o = rd_sel_i ? lo_q : hi_q;
    end
`endif

endmodule : hilo_regfile

`default_nettype wire

// File: rtl/hilo_sequencer.sv
// ============================================================================
// Module      : hilo_sequencer
// Description : Control-side companion of the multi-cycle mult/div core.
//               Accepts MULT/DIV/MTHI/MTLO requests, latches operands, runs
//               the core for a fixed cycle count and captures HI/LO.
//               Optional macro HILO_FWD_EN enables read forwarding in CAPT.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module hilo_sequencer
    import hilo_pkg::*;
#(
    parameter int DATA_W      = 32,
    parameter int MULT_CYCLES = 32,
    parameter int DIV_CYCLES  = 33
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start_i,
    input  logic [2:0]        op_i,
    input  logic [DATA_W-1:0] a_i,
    input  logic [DATA_W-1:0] b_i,
    input  logic              flush_i,
    input  logic              rd_en_i,
    input  logic              rd_sel_i,
    output logic [DATA_W-1:0] rd_data_o,
    output logic              stall_o,
    output logic              busy_o,
    output logic              done_o,
    output logic              div0_o,
    output logic [DATA_W-1:0] core_a_o,
    output logic [DATA_W-1:0] core_b_o,
    output logic [1:0]        core_ctrl_o,
    output logic              core_clr_o,
    input  logic [DATA_W-1:0] core_hi_i,
    input  logic [DATA_W-1:0] core_lo_i
);

    localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

    hilo_state_e       state_q;
    logic [CNT_W-1:0]  cnt_q;
    logic [DATA_W-1:0] a_q;
    logic [DATA_W-1:0] b_q;
    logic              is_div_q;
    logic [1:0]        ctrl_q;
    logic              clr_q;
    logic              busy_q;
    logic              done_q;
    logic              div0_q;

    logic              w_accept;
    logic              w_run_op;
    logic              w_pending;

    // A request is only taken in IDLE and only if no flush arrives with it
    assign w_accept = start_i && !flush_i && (state_q == ST_IDLE);
    // MULT always runs; DIV runs unless the divisor is zero
    assign w_run_op = (op_i == OP_MULT) || ((op_i == OP_DIV) && (b_i != '0));

    // Sequencer FSM with cycle counter, operand latches and registered outputs
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            a_q      <= '0;
            b_q      <= '0;
            is_div_q <= 1'b0;
            ctrl_q   <= CORE_IDLE;
            clr_q    <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            div0_q   <= 1'b0;
        end else begin
            clr_q  <= 1'b0;
            done_q <= 1'b0;
            div0_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (w_accept && w_run_op) begin
                        state_q  <= ST_CLR;
                        a_q      <= a_i;
                        b_q      <= b_i;
                        is_div_q <= (op_i == OP_DIV);
                        cnt_q    <= (op_i == OP_DIV) ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
                        clr_q    <= 1'b1;
                        busy_q   <= 1'b1;
                    end else if (w_accept && (op_i == OP_DIV)) begin
                        div0_q <= 1'b1;
                    end
                end
                ST_CLR: begin
                    if (flush_i) begin
                        state_q <= ST_IDLE;
                        busy_q  <= 1'b0;
                    end else begin
                        state_q <= ST_RUN;
                        ctrl_q  <= is_div_q ? CORE_DIV : CORE_MULT;
                    end
                end
                ST_RUN: begin
                    if (flush_i) begin
                        state_q <= ST_IDLE;
                        ctrl_q  <= CORE_IDLE;
                        busy_q  <= 1'b0;
                    end else begin
                        cnt_q <= (cnt_q == '0) ? '0 : cnt_q - CNT_W'(1);
                        if (cnt_q <= CNT_W'(1)) begin
                            state_q <= ST_CAPT;
                            ctrl_q  <= CORE_IDLE;
                            done_q  <= 1'b1;
                        end
                    end
                end
                default: begin
                    // CAPT always returns to IDLE; a flush only blocks the capture
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

`ifdef HILO_FWD_EN
    assign w_pending = (state_q == ST_CLR) || (state_q == ST_RUN);
`else
    assign w_pending = (state_q != ST_IDLE);
`endif

    assign stall_o     = rd_en_i && w_pending;
    assign busy_o      = busy_q;
    // A flush in CAPT suppresses the capture, so the pulse is masked too
    assign done_o      = done_q & ~flush_i;
    assign div0_o      = div0_q;
    assign core_a_o    = a_q;
    assign core_b_o    = b_q;
    assign core_ctrl_o = ctrl_q;
    assign core_clr_o  = clr_q;

    hilo_regfile #(
        .DATA_W (DATA_W)
    ) u_regfile (
        .clk       (clk),
        .reset     (reset),
        .capt_i    (state_q == ST_CAPT),
        .flush_i   (flush_i),
        .wr_hi_i   (w_accept && (op_i == OP_MTHI)),
        .wr_lo_i   (w_accept && (op_i == OP_MTLO)),
        .wr_data_i (a_i),
        .core_hi_i (core_hi_i),
        .core_lo_i (core_lo_i),
        .rd_sel_i  (rd_sel_i),
        .rd_data_o (rd_data_o)
    );

endmodule : hilo_sequencer

`default_nettype wire

// File: tb/tb_hilo_sequencer.sv
// ============================================================================
// Module      : tb_hilo_sequencer
// Description : Directed self-checking bench for hilo_sequencer with a
//               behavioural signed mult/div core model. Honors HILO_FWD_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_hilo_sequencer;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        start_i = 1'b0;
    logic [2:0]  op_i = 3'd0;
    logic [31:0] a_i = '0;
    logic [31:0] b_i = '0;
    logic        flush_i = 1'b0;
    logic        rd_en_i = 1'b0;
    logic        rd_sel_i = 1'b0;
    logic [31:0] rd_data_o;
    logic        stall_o, busy_o, done_o, div0_o;
    logic [31:0] core_a_o, core_b_o;
    logic [1:0]  core_ctrl_o;
    logic        core_clr_o;
    logic [31:0] core_hi_i = '0;
    logic [31:0] core_lo_i = '0;

    int n_chk  = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    hilo_sequencer u_dut (
        .clk         (clk),
        .reset       (reset),
        .start_i     (start_i),
        .op_i        (op_i),
        .a_i         (a_i),
        .b_i         (b_i),
        .flush_i     (flush_i),
        .rd_en_i     (rd_en_i),
        .rd_sel_i    (rd_sel_i),
        .rd_data_o   (rd_data_o),
        .stall_o     (stall_o),
        .busy_o      (busy_o),
        .done_o      (done_o),
        .div0_o      (div0_o),
        .core_a_o    (core_a_o),
        .core_b_o    (core_b_o),
        .core_ctrl_o (core_ctrl_o),
        .core_clr_o  (core_clr_o),
        .core_hi_i   (core_hi_i),
        .core_lo_i   (core_lo_i)
    );

    // Behavioural core: results become final only after the full cycle count;
    // before that it exposes junk so an early capture is visible.
    int          m_cnt = 0;
    logic signed [63:0] m_prod;
    always_comb m_prod = $signed(core_a_o) * $signed(core_b_o);

    always @(posedge clk) begin
        if (core_clr_o) begin
            m_cnt     <= 0;
            core_hi_i <= 32'h0;
            core_lo_i <= 32'h0;
        end else if (core_ctrl_o == 2'b01) begin
            m_cnt <= m_cnt + 1;
            if (m_cnt + 1 == 32) begin
                core_hi_i <= m_prod[63:32];
                core_lo_i <= m_prod[31:0];
            end else begin
                core_hi_i <= 32'hBAD0_0000 | 32'(m_cnt);
                core_lo_i <= 32'hBAD1_0000 | 32'(m_cnt);
            end
        end else if (core_ctrl_o == 2'b10) begin
            m_cnt <= m_cnt + 1;
            if (m_cnt + 1 == 33) begin
                core_lo_i <= $signed(core_a_o) / $signed(core_b_o);
                core_hi_i <= $signed(core_a_o) % $signed(core_b_o);
            end else begin
                core_hi_i <= 32'hBAD2_0000 | 32'(m_cnt);
                core_lo_i <= 32'hBAD3_0000 | 32'(m_cnt);
            end
        end
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic rd(input logic sel, output logic [31:0] val);
        rd_en_i  = 1'b1;
        rd_sel_i = sel;
        #1;
        val = rd_data_o;
    endtask

    task automatic mt(input logic [2:0] op, input logic [31:0] val);
        start_i = 1'b1;
        op_i    = op;
        a_i     = val;
        step();
        start_i = 1'b0;
        op_i    = 3'd0;
    endtask

    // Issue one request at cycle 0 and observe cycles 0..ncyc.
    // n = run length (0 for a request that must not go busy).
    task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                          input int n, input int ncyc, input logic sel,
                          output int done_at, output int done_cnt, output int div0_at,
                          output int bad_seq, output int bad_ab,
                          output logic [31:0] rd_capt, output logic [31:0] rd_after,
                          output logic stall_capt);
        logic exp_busy, exp_stall, exp_clr;
        logic [1:0] exp_ctrl;
        done_at = -1; done_cnt = 0; div0_at = -1; bad_seq = 0; bad_ab = 0;
        rd_capt = '0; rd_after = '0; stall_capt = 1'b0;
        rd_en_i = 1'b1; rd_sel_i = sel;
        for (int k = 0; k <= ncyc; k++) begin
            start_i = (k == 0);
            op_i    = op;
            a_i     = a;
            b_i     = b;
            #1;
            exp_busy = (n > 0) && (k >= 1) && (k <= n + 2);
            exp_clr  = (n > 0) && (k == 1);
            exp_ctrl = ((n > 0) && (k >= 2) && (k <= n + 1)) ? ((op == 3'd2) ? 2'b10 : 2'b01) : 2'b00;
`ifdef HILO_FWD_EN
            exp_stall = (n > 0) && (k >= 1) && (k <= n + 1);
`else
            exp_stall = exp_busy;
`endif
            if (busy_o !== exp_busy || stall_o !== exp_stall ||
                core_clr_o !== exp_clr || core_ctrl_o !== exp_ctrl) bad_seq++;
            if (exp_busy && (core_a_o !== a || core_b_o !== b)) bad_ab++;
            if (done_o) begin
                done_cnt++;
                if (done_at < 0) done_at = k;
            end
            if (div0_o && div0_at < 0) div0_at = k;
            if (k == n + 2) begin rd_capt = rd_data_o; stall_capt = stall_o; end
            if (k == n + 3) rd_after = rd_data_o;
            step();
        end
        start_i = 1'b0;
        op_i    = 3'd0;
    endtask

    int          d_at, d_cnt, z_at, b_seq, b_ab;
    logic [31:0] r_capt, r_after, v;
    logic        s_capt;

    initial begin
        // ---------------- reset state ----------------
        rd_en_i = 1'b1;
        repeat (2) step();
        chk("rst_busy", busy_o, 0);
        chk("rst_stall", stall_o, 0);
        chk("rst_ctrl", core_ctrl_o, 0);
        chk("rst_outs", {done_o, div0_o, core_clr_o}, 0);
        chk("rst_core_a", core_a_o, 0);
        chk("rst_rd", rd_data_o, 0);
        #3 reset = 1'b1;
        step();

        // ---------------- MULT 7 * -3 ----------------
        run_op(3'd1, 32'd7, 32'hFFFF_FFFD, 32, 38, 1'b0, d_at, d_cnt, z_at, b_seq, b_ab, r_capt, r_after, s_capt);
        chk("mult_done_at", d_at, 34);
        chk("mult_done_cnt", d_cnt, 1);
        chk("mult_seq", b_seq, 0);
        chk("mult_ab", b_ab, 0);
        rd(1'b0, v); chk("mult_hi", v, 32'hFFFF_FFFF);
        rd(1'b1, v); chk("mult_lo", v, 32'hFFFF_FFEB);
        step();

        // ---------------- DIV -7 / 2 ----------------
        run_op(3'd2, 32'hFFFF_FFF9, 32'd2, 33, 39, 1'b0, d_at, d_cnt, z_at, b_seq, b_ab, r_capt, r_after, s_capt);
        chk("div_done_at", d_at, 35);
        chk("div_seq", b_seq, 0);
        chk("div_ab", b_ab, 0);
        rd(1'b0, v); chk("div_hi", v, 32'hFFFF_FFFF);
        rd(1'b1, v); chk("div_lo", v, 32'hFFFF_FFFD);
        step();

        // ---------------- MTHI/MTLO then DIV by zero ----------------
        mt(3'd3, 32'h1234);
        mt(3'd4, 32'h5678);
        rd(1'b0, v); chk("mthi", v, 32'h1234);
        rd(1'b1, v); chk("mtlo", v, 32'h5678);
        run_op(3'd2, 32'd99, 32'd0, 0, 6, 1'b0, d_at, d_cnt, z_at, b_seq, b_ab, r_capt, r_after, s_capt);
        chk("div0_at", z_at, 1);
        chk("div0_seq", b_seq, 0);
        chk("div0_nodone", d_cnt, 0);
        rd(1'b0, v); chk("div0_hi", v, 32'h1234);
        rd(1'b1, v); chk("div0_lo", v, 32'h5678);
        step();

        // ---------------- MULT flushed at T+10 ----------------
        d_cnt   = 0;
        start_i = 1'b1; op_i = 3'd1; a_i = 32'd2; b_i = 32'd3;
        for (int k = 0; k < 45; k++) begin
            flush_i = (k == 10);
            #1;
            if (done_o) d_cnt++;
            if (k == 11) begin
                chk("flush_busy", busy_o, 0);
                chk("flush_ctrl", core_ctrl_o, 0);
            end
            step();
            start_i = 1'b0; op_i = 3'd0;
        end
        flush_i = 1'b0;
        chk("flush_nodone", d_cnt, 0);
        rd(1'b0, v); chk("flush_hi", v, 32'h1234);
        rd(1'b1, v); chk("flush_lo", v, 32'h5678);
        step();
        run_op(3'd1, 32'd100, 32'd200, 32, 38, 1'b0, d_at, d_cnt, z_at, b_seq, b_ab, r_capt, r_after, s_capt);
        chk("post_flush_done_at", d_at, 34);
        rd(1'b1, v); chk("post_flush_lo", v, 32'd20000);
        rd(1'b0, v); chk("post_flush_hi", v, 32'd0);
        step();

        // ---------------- reset in the middle of a DIV ----------------
        start_i = 1'b1; op_i = 3'd2; a_i = 32'd100; b_i = 32'd7;
        step();
        start_i = 1'b0; op_i = 3'd0;
        repeat (19) step();
        chk("pre_rst_busy", busy_o, 1);
        reset = 1'b0;
        #1;
        chk("mid_rst_busy", busy_o, 0);
        chk("mid_rst_ctrl", core_ctrl_o, 0);
        chk("mid_rst_core_a", core_a_o, 0);
        rd(1'b1, v); chk("mid_rst_lo", v, 0);
        step();
        #3 reset = 1'b1;
        step();
        mt(3'd4, 32'hA5);
        rd(1'b1, v); chk("rst_mtlo", v, 32'hA5);
        step();

        // ---------------- MULT 3*5 with LO read held ----------------
        run_op(3'd1, 32'd3, 32'd5, 32, 38, 1'b1, d_at, d_cnt, z_at, b_seq, b_ab, r_capt, r_after, s_capt);
        chk("rd_seq", b_seq, 0);
`ifdef HILO_FWD_EN
        chk("fwd_rd_capt", r_capt, 32'hF);
        chk("fwd_stall_capt", s_capt, 0);
`else
        chk("nofwd_rd_capt", r_capt, 32'hA5);
        chk("nofwd_stall_capt", s_capt, 1);
        chk("nofwd_rd_after", r_after, 32'hF);
`endif
        rd_en_i = 1'b0;
        step();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule : tb_hilo_sequencer

`default_nettype wire
